// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter in front of a single-port memory.
// One access in flight at a time; all outputs registered.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {StIdle, StAccess, StRdwait} state_e;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic              pick;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        rvalid0_d     = 1'b0;
        rvalid1_d     = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        mem_address_d = mem_address_q;
        mem_wr_en_d   = 1'b0;
        mem_data_in_d = mem_data_in_q;
        pick          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // On a tie the port that was not granted last wins
                    pick          = (req0 && req1) ? ~last_q : req1;
                    sel_d         = pick;
                    mem_address_d = pick ? addr1 : addr0;
                    mem_data_in_d = pick ? wdata1 : wdata0;
                    mem_wr_en_d   = pick ? we1 : we0;
                    gnt0_d        = ~pick;
                    gnt1_d        = pick;
                    state_d       = StAccess;
                end
            end
            StAccess: begin
                last_d = sel_q;
                if (mem_wr_en_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = StRdwait;
                end
            end
            StRdwait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    if (sel_q) begin
                        rdata1_d  = mem_data_out;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = mem_data_out;
                        rvalid0_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            sel_q         <= 1'b0;
            last_q        <= 1'b1;
            cnt_q         <= '0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            busy_q        <= 1'b0;
            mem_address_q <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            busy_q        <= busy_d;
            mem_address_q <= mem_address_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign busy        = busy_q;
    assign mem_address = mem_address_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: four instances (RD_LAT 1..4) share the same
// requester stimulus, each with its own memory model; instance M (RD_LAT=3) is the main target.
module tb_mem_arbiter;

    localparam int M = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        gnt0_w [4];
    logic        gnt1_w [4];
    logic        rvalid0_w [4];
    logic        rvalid1_w [4];
    logic [15:0] rdata0_w [4];
    logic [15:0] rdata1_w [4];
    logic        busy_w [4];
    logic [15:0] mem_address_w [4];
    logic        mem_wr_en_w [4];
    logic [15:0] mem_data_in_w [4];
    logic [15:0] mem_data_out_w [4];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        logic [15:0] mem_q [256];
        logic [15:0] pipe_q [4];

        mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(g + 1)) u_dut (
            .clock        (clock),
            .reset        (reset),
            .req0         (req0),
            .req1         (req1),
            .we0          (we0),
            .we1          (we1),
            .addr0        (addr0),
            .addr1        (addr1),
            .wdata0       (wdata0),
            .wdata1       (wdata1),
            .gnt0         (gnt0_w[g]),
            .gnt1         (gnt1_w[g]),
            .rvalid0      (rvalid0_w[g]),
            .rvalid1      (rvalid1_w[g]),
            .rdata0       (rdata0_w[g]),
            .rdata1       (rdata1_w[g]),
            .busy         (busy_w[g]),
            .mem_address  (mem_address_w[g]),
            .mem_wr_en    (mem_wr_en_w[g]),
            .mem_data_in  (mem_data_in_w[g]),
            .mem_data_out (mem_data_out_w[g])
        );

        // Memory with g+1 cycles from address to data
        always @(posedge clock) begin
            if (mem_wr_en_w[g]) mem_q[mem_address_w[g][7:0]] <= mem_data_in_w[g];
            pipe_q[0] <= mem_q[mem_address_w[g][7:0]];
            for (int k = 1; k < 4; k++) pipe_q[k] <= pipe_q[k-1];
        end
        assign mem_data_out_w[g] = pipe_q[g];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input int port, output int c);
        bit found = 1'b0;
        c = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if ((port == 0 && gnt0_w[M]) || (port == 1 && gnt1_w[M])) begin
                found = 1'b1;
                c = cyc;
            end
        end
        check_eq($sformatf("gnt%0d_seen", port), 32'(found), 1);
    endtask

    task automatic wait_rvalid(input int port, output int c, output logic [15:0] d);
        bit found = 1'b0;
        c = -1;
        d = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (port == 0 && rvalid0_w[M]) begin
                found = 1'b1; c = cyc; d = rdata0_w[M];
            end else if (port == 1 && rvalid1_w[M]) begin
                found = 1'b1; c = cyc; d = rdata1_w[M];
            end
        end
        check_eq($sformatf("rvalid%0d_seen", port), 32'(found), 1);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 80 && quiet < 2; i++) begin
            @(negedge clock);
            if (!busy_w[0] && !busy_w[1] && !busy_w[2] && !busy_w[3]) quiet++;
            else quiet = 0;
        end
        check_eq("idle_reached", 32'(quiet), 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, r, c, ng, nrv0, nrv1;
        int gc [3];
        int sg [4];
        int sr [4];
        logic [15:0] d, sd [4], saved_rdata1;
        bit seen;

        // Reset with both ports requesting
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) begin
            @(negedge clock);
            check_eq("rst_gnt0", 32'(gnt0_w[M]), 0);
            check_eq("rst_gnt1", 32'(gnt1_w[M]), 0);
            check_eq("rst_busy", 32'(busy_w[M]), 0);
            check_eq("rst_wr_en", 32'(mem_wr_en_w[M]), 0);
            check_eq("rst_addr", 32'(mem_address_w[M]), 0);
            check_eq("rst_din", 32'(mem_data_in_w[M]), 0);
            check_eq("rst_rvalid", 32'({rvalid0_w[M], rvalid1_w[M]}), 0);
            check_eq("rst_rdata0", 32'(rdata0_w[M]), 0);
            check_eq("rst_rdata1", 32'(rdata1_w[M]), 0);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (gnt0_w[M] || gnt1_w[M]) seen = 1'b1;
        end
        check_eq("first_gnt_seen", 32'(seen), 1);
        check_eq("first_gnt_is_0", 32'({gnt1_w[M], gnt0_w[M]}), 1);
        req0 = 1'b0;
        wait_gnt(1, c);
        req1 = 1'b0;
        wait_idle();

        // Port 0 write then read
        saved_rdata1 = rdata1_w[M];
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'd4; wdata0 = 16'hBEEF;
        wait_gnt(0, a);
        check_eq("wr_en_with_gnt", 32'(mem_wr_en_w[M]), 1);
        check_eq("wr_addr", 32'(mem_address_w[M]), 4);
        check_eq("wr_data", 32'(mem_data_in_w[M]), 32'h0000BEEF);
        check_eq("wr_no_gnt1", 32'(gnt1_w[M]), 0);
        req0 = 1'b0;
        @(negedge clock);
        check_eq("wr_en_pulse", 32'(mem_wr_en_w[M]), 0);
        check_eq("gnt0_pulse", 32'(gnt0_w[M]), 0);
        check_eq("wr_back_idle", 32'(busy_w[M]), 0);
        check_eq("addr_held", 32'(mem_address_w[M]), 4);
        req0 = 1'b1; we0 = 1'b0;
        wait_gnt(0, a);
        check_eq("rd_wr_en_low", 32'(mem_wr_en_w[M]), 0);
        req0 = 1'b0;
        wait_rvalid(0, r, d);
        check_eq("rd_latency", 32'(r - a), 4);
        check_eq("rd_data", 32'(d), 32'h0000BEEF);
        check_eq("rd_rdata1_kept", 32'(rdata1_w[M]), 32'(saved_rdata1));
        @(negedge clock);
        check_eq("rvalid_pulse", 32'(rvalid0_w[M]), 0);
        check_eq("rdata0_holds", 32'(rdata0_w[M]), 32'h0000BEEF);
        wait_idle();

        // Contention: both ports read, grants must alternate 0,1,0,1
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'd8; wdata1 = 16'h1234;
        wait_gnt(1, c);
        req1 = 1'b0;
        wait_idle();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd4;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd8;
        ng = 0; nrv0 = 0; nrv1 = 0;
        for (int i = 0; i < 100 && (ng < 4 || nrv0 + nrv1 < 4); i++) begin
            @(negedge clock);
            if (gnt0_w[M] || gnt1_w[M]) begin
                if (ng < 4) check_eq($sformatf("order%0d", ng),
                                     32'({gnt1_w[M], gnt0_w[M]}), (ng % 2 == 0) ? 1 : 2);
                ng++;
                if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
            if (rvalid0_w[M]) begin
                check_eq("cont_rdata0", 32'(rdata0_w[M]), 32'h0000BEEF);
                nrv0++;
            end
            if (rvalid1_w[M]) begin
                check_eq("cont_rdata1", 32'(rdata1_w[M]), 32'h00001234);
                nrv1++;
            end
        end
        check_eq("cont_ngnt", 32'(ng), 4);
        check_eq("cont_nrv0", 32'(nrv0), 2);
        check_eq("cont_nrv1", 32'(nrv1), 2);
        wait_idle();

        // Back-to-back writes on port 1 with req held
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'd1; wdata1 = 16'hA001;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(1, gc[k]);
            if (k < 2) begin
                addr1  = 16'(k + 2);
                wdata1 = 16'hA001 + 16'(k + 1);
            end else begin
                req1 = 1'b0;
            end
        end
        check_eq("b2b_gap01", 32'(gc[1] - gc[0]), 2);
        check_eq("b2b_gap12", 32'(gc[2] - gc[1]), 2);
        wait_idle();
        for (int k = 1; k <= 3; k++) begin
            req1 = 1'b1; we1 = 1'b0; addr1 = 16'(k);
            wait_gnt(1, a);
            req1 = 1'b0;
            wait_rvalid(1, r, d);
            check_eq($sformatf("b2b_rb%0d", k), 32'(d), 32'hA000 + 32'(k));
            check_eq($sformatf("b2b_lat%0d", k), 32'(r - a), 4);
            wait_idle();
        end

        // Reset during RDWAIT abandons the read
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd4;
        wait_gnt(0, a);
        req0 = 1'b0;
        @(negedge clock);
        check_eq("mid_busy", 32'(busy_w[M]), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("mid_rst_idle", 32'(busy_w[M]), 0);
        check_eq("mid_rst_rdata0", 32'(rdata0_w[M]), 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (rvalid0_w[M]) seen = 1'b1;
        end
        check_eq("mid_no_rvalid", 32'(seen), 0);
        check_eq("mid_rdata0_zero", 32'(rdata0_w[M]), 0);
        req0 = 1'b1;
        wait_gnt(0, a);
        req0 = 1'b0;
        wait_rvalid(0, r, d);
        check_eq("reissue_data", 32'(d), 32'h0000BEEF);
        check_eq("reissue_lat", 32'(r - a), 4);
        wait_idle();

        // Latency sweep across all four instances
        for (int g = 0; g < 4; g++) begin sg[g] = -1; sr[g] = -1; sd[g] = '0; end
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd4;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            for (int g = 0; g < 4; g++) begin
                if (gnt0_w[g] && sg[g] < 0) sg[g] = cyc;
                if (rvalid0_w[g] && sr[g] < 0) begin sr[g] = cyc; sd[g] = rdata0_w[g]; end
            end
            if (gnt0_w[M]) req0 = 1'b0;
        end
        for (int g = 0; g < 4; g++) begin
            check_eq($sformatf("sweep_lat%0d", g + 1), 32'(sr[g] - sg[g]), 32'(g + 2));
            check_eq($sformatf("sweep_data%0d", g + 1), 32'(sd[g]), 32'h0000BEEF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
